// File: rtl/button_debounce_pkg.sv
// Shared definitions for the pushbutton conditioning block.
package button_debounce_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } deb_state_e;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: polarity fix, 2-flop synchronizer, debounce FSM,
// hold counter and registered press/release/long-press pulses.
module button_debounce_ch
  import button_debounce_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW        = 1,
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
  input  logic extra_clk,
  input  logic extra_rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             pressed_c;
  logic             s1;
  logic             s2;
  deb_state_e       state;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;

  // Normalise to 1 = pressed before the first sync flop.
  assign pressed_c = btn_raw ^ (ACTIVE_LOW != 0);

  always_ff @(posedge extra_clk) begin
    if (!extra_rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= RELEASED;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      s1          <= pressed_c;
      s2          <= s1;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;

      // Hold counter runs across release bounces and saturates, so long fires once per press.
      if (btn_level && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + CNT_ONE;
        btn_long <= (hold_cnt == HOLD_MAX - CNT_ONE);
      end

      case (state)
        RELEASED: begin
          if (s2) begin
            state   <= PRESS_PEND;
            deb_cnt <= CNT_ONE;
          end
        end
        PRESS_PEND: begin
          if (!s2) begin
            state   <= RELEASED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            deb_cnt <= deb_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state   <= RELEASE_PEND;
            deb_cnt <= CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (s2) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= RELEASED;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
            deb_cnt     <= '0;
          end else begin
            deb_cnt <= deb_cnt + CNT_ONE;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel pushbutton conditioner: one independent debounce channel per pin.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned BTN_NUM           = 1,
  parameter int unsigned ACTIVE_LOW        = 1,
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
  input  logic               extra_clk,
  input  logic               extra_rst_n,
  input  logic [BTN_NUM-1:0] btn_raw,
  output logic [BTN_NUM-1:0] btn_level,
  output logic [BTN_NUM-1:0] btn_press,
  output logic [BTN_NUM-1:0] btn_release,
  output logic [BTN_NUM-1:0] btn_long
);

  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("button_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_ch
    button_debounce_ch #(
      .ACTIVE_LOW        (ACTIVE_LOW),
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .CNT_W             (CNT_W)
    ) u_ch (
      .extra_clk   (extra_clk),
      .extra_rst_n (extra_rst_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed vector table, hand-written corner
// sequences and random bouncing, all cross-checked against a run-length model.
module tb_button_debounce;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic         extra_clk = 1'b0;
  logic         extra_rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  int checks   = 0;
  int failures = 0;

  always #5 extra_clk = ~extra_clk;

  button_debounce #(
    .BTN_NUM           (N),
    .ACTIVE_LOW        (1),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .CNT_W             (32)
  ) dut (
    .extra_clk   (extra_clk),
    .extra_rst_n (extra_rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  // Model: pin seen two edges late; level flips after DEB consecutive
  // disagreeing samples; long fires LONG edges after a press with no release between.
  logic       m_s1 [N];
  logic       m_s2 [N];
  logic       m_lvl[N];
  int         m_run[N];
  int         m_press_edge[N];
  int         m_rel_edge[N];
  logic       m_has[N];
  int         edge_n = 0;
  logic [N-1:0] e_lvl, e_prs, e_rel, e_lng;
  int         n_press[N], n_rel[N], n_long[N];

  task automatic model_edge(input logic rst_n, input logic [N-1:0] raw);
    logic obs;
    edge_n++;
    for (int c = 0; c < N; c++) begin
      e_prs[c] = 1'b0;
      e_rel[c] = 1'b0;
      e_lng[c] = 1'b0;
      if (!rst_n) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_run[c] = 0; m_has[c] = 1'b0;
        m_press_edge[c] = -1; m_rel_edge[c] = -1;
      end else begin
        obs     = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = ~raw[c];
        e_lng[c] = m_has[c] && m_lvl[c] && (edge_n - m_press_edge[c] == LONG)
                   && (m_rel_edge[c] < m_press_edge[c]);
        if (obs != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == DEB) begin
          m_run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            e_prs[c] = 1'b1; m_press_edge[c] = edge_n; m_has[c] = 1'b1;
          end else begin
            e_rel[c] = 1'b1; m_rel_edge[c] = edge_n;
          end
        end
      end
      e_lvl[c] = m_lvl[c];
    end
  endtask

  // One clock: drive, clock, model, check DUT against model, tally pulses.
  task automatic step(input logic rst_n, input logic [N-1:0] raw);
    extra_rst_n = rst_n;
    btn_raw     = raw;
    @(posedge extra_clk);
    model_edge(rst_n, raw);
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== {e_lvl, e_prs, e_rel, e_lng}) begin
      failures++;
      $display("FAIL model edge=%0d lvl=%b/%b press=%b/%b rel=%b/%b long=%b/%b (dut/model)",
               edge_n, btn_level, e_lvl, btn_press, e_prs, btn_release, e_rel, btn_long, e_lng);
    end
    for (int c = 0; c < N; c++) begin
      if (btn_press[c] === 1'b1)   n_press[c]++;
      if (btn_release[c] === 1'b1) n_rel[c]++;
      if (btn_long[c] === 1'b1)    n_long[c]++;
    end
    @(negedge extra_clk);
  endtask

  task automatic hold(input logic [N-1:0] raw, input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b1, raw);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic [N-1:0] raw;
    int           rep;
    logic [N-1:0] lvl, prs, rel, lng;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] raw, input int rep,
                              input logic [N-1:0] l, input logic [N-1:0] p,
                              input logic [N-1:0] rl, input logic [N-1:0] lg);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.rep = rep; v.lvl = l; v.prs = p; v.rel = rl; v.lng = lg;
    return v;
  endfunction

  int base_p, base_r, base_l, base_p1, base_r1, base_l1;
  int run_left[N];
  logic [N-1:0] rnd_raw;

  initial begin
    for (int c = 0; c < N; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
    end

    // Reset with pins pressed-idle, ch0 press, long press, release, glitch.
    vecs.push_back(mk(1'b0, 2'b11, 3,  2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 20, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 5,  2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1,  2'b01, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 15, 2'b01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1,  2'b01, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(1'b1, 2'b10, 10, 2'b01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 5,  2'b01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 1,  2'b00, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 5,  2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 3,  2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 10, 2'b00, 2'b00, 2'b00, 2'b00));

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        step(vecs[i].rst_n, vecs[i].raw);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_long} !==
            {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lng}) begin
          failures++;
          $display("FAIL vec%0d.%0d lvl=%b/%b press=%b/%b rel=%b/%b long=%b/%b (got/want)",
                   i, r, btn_level, vecs[i].lvl, btn_press, vecs[i].prs,
                   btn_release, vecs[i].rel, btn_long, vecs[i].lng);
        end
      end
    end

    // Bouncy press: three 3-cycle bounces then stable -> one press, one long.
    base_p = n_press[0]; base_l = n_long[0]; base_r = n_rel[0];
    for (int b = 0; b < 3; b++) begin
      hold(2'b10, 3);
      hold(2'b11, 2);
    end
    hold(2'b10, 30);
    check_int("bounce_press_cnt", n_press[0] - base_p, 1);
    check_int("bounce_long_cnt", n_long[0] - base_l, 1);
    hold(2'b11, 10);
    check_int("bounce_rel_cnt", n_rel[0] - base_r, 1);
    hold(2'b10, 30);
    check_int("relong_cnt", n_long[0] - base_l, 2);
    hold(2'b11, 10);

    // Both channels pressed together, then a 2-cycle release bounce on ch1.
    hold(2'b00, 5);
    step(1'b1, 2'b00);
    checks++;
    if (btn_press !== 2'b11) begin
      failures++;
      $display("FAIL dual_press got=%b want=11", btn_press);
    end
    base_r1 = n_rel[1]; base_l1 = n_long[1];
    hold(2'b10, 2);
    hold(2'b00, 20);
    check_int("ch1_bounce_rel", n_rel[1] - base_r1, 0);
    check_int("ch1_long_cnt", n_long[1] - base_l1, 1);
    hold(2'b11, 10);

    // Reset while ch0 pressed: level drops silently, then re-debounces.
    hold(2'b10, 8);
    step(1'b0, 2'b10);
    checks++;
    if (btn_level !== 2'b00 || btn_release !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid lvl=%b rel=%b want 00/00", btn_level, btn_release);
    end
    hold(2'b10, 5);
    step(1'b1, 2'b10);
    checks++;
    if (btn_press !== 2'b01 || btn_level !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_press press=%b lvl=%b want 01/01", btn_press, btn_level);
    end
    hold(2'b11, 10);

    // Random bouncing pins with occasional resets.
    rnd_raw = 2'b11;
    for (int c = 0; c < N; c++) run_left[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (run_left[c] == 0) begin
          rnd_raw[c] = ~rnd_raw[c];
          run_left[c] = ($urandom_range(9, 0) < 7) ? int'($urandom_range(5, 1))
                                                     : int'($urandom_range(30, 5));
        end
        run_left[c]--;
      end
      step(($urandom_range(799, 0) != 0), rnd_raw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
